// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and helpers for the FF46 OAM DMA engine.
// Holds the engine state encoding, default transfer geometry and source-page mapping.
package dmg_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    LAST  = 2'd3
  } dma_state_t;

  localparam int DEF_OAM_LEN   = 160;
  localparam int DEF_START_DLY = 1;

  // Pages E0..FF alias the work RAM echo, so they are folded down by 0x20.
  function automatic logic [7:0] dma_src_map(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the OAM DMA engine and the rest of the system:
// CPU FF46 access, source read bus and the OAM write port with its lock.
interface oam_dma_ctrl_if;
  logic        ff46_wr;
  logic        ff46_rd;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic [7:0]  src_d;
  logic [15:0] src_a;
  logic        src_rd;
  logic        src_vram;
  logic [7:0]  oam_a;
  logic [7:0]  oam_d;
  logic        oam_wr;
  logic        oam_lock;

  modport master (
    input  ff46_wr, ff46_rd, d_in, src_d,
    output d_out, src_a, src_rd, src_vram, oam_a, oam_d, oam_wr, oam_lock
  );

  modport slave (
    output ff46_wr, ff46_rd, d_in, src_d,
    input  d_out, src_a, src_rd, src_vram, oam_a, oam_d, oam_wr, oam_lock
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// FF46 OAM DMA engine: copies OAM_LEN bytes from page {src_hi,00} into OAM,
// one byte per machine cycle, reading byte n while writing byte n-1.
module oam_dma_ctrl
  import dmg_dma_pkg::*;
#(
  parameter int OAM_LEN   = DEF_OAM_LEN,
  parameter int START_DLY = DEF_START_DLY
) (
  input  logic           clk1,
  input  logic           reset,
  input  logic           mcyc,
  oam_dma_ctrl_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);
  localparam logic [7:0] DLY_END  = 8'(START_DLY - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  dly_q, dly_d;
  logic [7:0]  ff46_q, ff46_d;

  logic [15:0] src_a_q, src_a_d;
  logic        src_rd_q, src_rd_d;
  logic        src_vram_q, src_vram_d;
  logic [7:0]  oam_a_q, oam_a_d;
  logic [7:0]  oam_d_q, oam_d_d;
  logic        oam_wr_q, oam_wr_d;
  logic        oam_lock_q, oam_lock_d;

  // State register
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 8'h00;
      dly_q   <= 8'h00;
      ff46_q  <= 8'hFF;
    end else if (mcyc) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      ff46_q  <= ff46_d;
    end
  end

  // Next-state logic; a CPU write restarts from any state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    ff46_d  = ff46_q;
    if (bus.ff46_wr) begin
      state_d = START;
      dly_d   = 8'h00;
      ff46_d  = bus.d_in;
    end else begin
      case (state_q)
        START: begin
          if (dly_q == DLY_END) begin
            state_d = XFER;
            idx_d   = 8'h00;
          end else begin
            dly_d = dly_q + 8'd1;
          end
        end
        XFER: begin
          if (idx_q == LAST_IDX) state_d = LAST;
          else                   idx_d   = idx_q + 8'd1;
        end
        LAST:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: values for the coming machine cycle. A read this cycle
  // always becomes a write next cycle, which also commits the byte pending
  // across a restart and produces the final write in LAST.
  always_comb begin
    src_rd_d   = (state_d == XFER);
    src_a_d    = src_rd_d ? {dma_src_map(ff46_d), idx_d} : src_a_q;
    src_vram_d = (src_a_d[15:13] == 3'b100);
    oam_wr_d   = src_rd_q;
    oam_a_d    = src_rd_q ? src_a_q[7:0] : oam_a_q;
    oam_d_d    = src_rd_q ? bus.src_d    : oam_d_q;
    oam_lock_d = (state_d == XFER) || (state_d == LAST) ||
                 ((state_d == START) && oam_lock_q);
  end

  // Output register
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      src_a_q    <= 16'h0000;
      src_rd_q   <= 1'b0;
      src_vram_q <= 1'b0;
      oam_a_q    <= 8'h00;
      oam_d_q    <= 8'h00;
      oam_wr_q   <= 1'b0;
      oam_lock_q <= 1'b0;
    end else if (mcyc) begin
      src_a_q    <= src_a_d;
      src_rd_q   <= src_rd_d;
      src_vram_q <= src_vram_d;
      oam_a_q    <= oam_a_d;
      oam_d_q    <= oam_d_d;
      oam_wr_q   <= oam_wr_d;
      oam_lock_q <= oam_lock_d;
    end
  end

  assign bus.src_a    = src_a_q;
  assign bus.src_rd   = src_rd_q;
  assign bus.src_vram = src_vram_q;
  assign bus.oam_a    = oam_a_q;
  assign bus.oam_d    = oam_d_q;
  assign bus.oam_wr   = oam_wr_q;
  assign bus.oam_lock = oam_lock_q;
  // Readback is combinational so a read in the same cycle as a write sees the old value.
  assign bus.d_out    = bus.ff46_rd ? ff46_q : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus pushes expected reads/writes,
// a monitor pops and compares them on every machine cycle.
module tb_oam_dma_ctrl;
  import dmg_dma_pkg::*;

  logic clk1  = 1'b0;
  logic reset = 1'b1;
  logic mcyc  = 1'b0;
  int   ph    = 0;

  oam_dma_ctrl_if bus();

  oam_dma_ctrl dut (
    .clk1  (clk1),
    .reset (reset),
    .mcyc  (mcyc),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    ph   = (ph + 1) % 4;
    mcyc = (ph == 0);
  end

  logic [7:0] salt = 8'h00;
  assign bus.src_d = bus.src_a[7:0] ^ 8'h5A ^ salt;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [7:0]  d;
  } xact_t;

  xact_t      rq[$];
  xact_t      wq[$];
  int         total = 0;
  int         bad   = 0;
  int         mc    = 0;
  int         lo    = 0;
  int         hi    = -1;
  int         lock_cnt = 0;
  int         wr_cnt   = 0;
  logic [7:0] ff46_model = 8'hFF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (mcyc %0d)", nm, act, exp, mc);
    end
  endtask

  // Monitor
  initial begin
    xact_t x;
    forever begin
      @(posedge clk1);
      if (mcyc) begin
        #1;
        mc++;
        chk("oam_lock", {31'd0, bus.oam_lock}, {31'd0, (mc >= lo && mc <= hi)});
        if (bus.oam_lock) lock_cnt++;
        if (bus.src_rd) begin
          chk("rd_expected", {31'd0, rq.size() != 0}, 1);
          if (rq.size() != 0) begin
            x = rq.pop_front();
            chk("rd_cycle", mc, x.cyc);
            chk("src_a", {16'd0, bus.src_a}, {16'd0, x.a});
            chk("src_vram", {31'd0, bus.src_vram},
                {31'd0, (x.a >= 16'h8000 && x.a < 16'hA000)});
          end
        end else if (rq.size() != 0) begin
          chk("rd_missing", {31'd0, mc < rq[0].cyc}, 1);
        end
        if (bus.oam_wr) begin
          wr_cnt++;
          chk("wr_expected", {31'd0, wq.size() != 0}, 1);
          if (wq.size() != 0) begin
            x = wq.pop_front();
            chk("wr_cycle", mc, x.cyc);
            chk("oam_a", {24'd0, bus.oam_a}, {16'd0, x.a});
            chk("oam_d", {24'd0, bus.oam_d}, {24'd0, x.d});
          end
        end else if (wq.size() != 0) begin
          chk("wr_missing", {31'd0, mc < wq[0].cyc}, 1);
        end
      end
    end
  end

  task automatic next_mc();
    do @(posedge clk1); while (mcyc !== 1'b1);
    #2;
  endtask

  // FF46 write in the current machine cycle; the model is a list of
  // 160 reads two cycles later and 160 writes three cycles later.
  task automatic issue(input logic [7:0] v, input bit chk_old);
    int m;
    int eff;
    m = mc;
    bus.d_in    = v;
    bus.ff46_wr = 1'b1;
    if (chk_old) begin
      #1;
      chk("rd_wr_same_cycle", {24'd0, bus.d_out}, {24'd0, ff46_model});
    end
    if (m <= hi) begin
      while (rq.size() != 0 && rq[$].cyc > m)     void'(rq.pop_back());
      while (wq.size() != 0 && wq[$].cyc > m + 1) void'(wq.pop_back());
    end else begin
      lo = m + 2;
    end
    hi  = m + 2 + 160;
    eff = (int'(v) >= 224) ? int'(v) - 32 : int'(v);
    for (int k = 0; k < 160; k++) begin
      rq.push_back('{m + 2 + k, 16'(eff * 256 + k), 8'h00});
      wq.push_back('{m + 3 + k, 16'(k), 8'(k) ^ 8'h5A ^ salt});
    end
    ff46_model = v;
    next_mc();
    bus.ff46_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mc <= hi || rq.size() != 0 || wq.size() != 0) && n < 2000) begin
      next_mc();
      n++;
    end
    chk("idle_timeout", {31'd0, n < 2000}, 1);
  endtask

  task automatic wait_byte(input int r);
    int n = 0;
    while (!(bus.src_rd && int'(bus.src_a[7:0]) == r) && n < 400) begin
      next_mc();
      n++;
    end
    chk("wait_byte_timeout", {31'd0, n < 400}, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc0;
    int wc0;
    int n;
    int r;
    logic [7:0] v;
    bus.ff46_wr = 1'b0;
    bus.ff46_rd = 1'b0;
    bus.d_in    = 8'h00;

    #12;
    chk("rst_src_a",    {16'd0, bus.src_a}, 0);
    chk("rst_oam_a",    {24'd0, bus.oam_a}, 0);
    chk("rst_oam_d",    {24'd0, bus.oam_d}, 0);
    chk("rst_d_out",    {24'd0, bus.d_out}, 0);
    chk("rst_lock",     {31'd0, bus.oam_lock}, 0);
    chk("rst_oam_wr",   {31'd0, bus.oam_wr}, 0);
    chk("rst_src_rd",   {31'd0, bus.src_rd}, 0);
    bus.ff46_rd = 1'b1;
    #1;
    chk("rst_ff46_readback", {24'd0, bus.d_out}, 32'hFF);
    bus.ff46_rd = 1'b0;
    @(negedge clk1);
    reset = 1'b0;
    next_mc();
    next_mc();

    // Basic copy
    lc0 = lock_cnt;
    wc0 = wr_cnt;
    issue(8'hC1, 1'b0);
    wait_idle();
    chk("basic_lock_cycles", lock_cnt - lc0, 161);
    chk("basic_writes", wr_cnt - wc0, 160);

    // Echo mapping and VRAM source
    issue(8'hFE, 1'b0);
    wait_idle();
    issue(8'h80, 1'b0);
    wait_idle();

    // Restart mid-transfer
    wc0 = wr_cnt;
    issue(8'hC0, 1'b0);
    wait_byte(49);
    issue(8'hD0, 1'b0);
    wait_idle();
    chk("restart_writes", wr_cnt - wc0, 210);

    // Restart in the final-write cycle
    issue(8'h12, 1'b0);
    n = 0;
    while (mc < hi && n < 400) begin
      next_mc();
      n++;
    end
    chk("last_wait_timeout", {31'd0, n < 400}, 1);
    issue(8'h34, 1'b0);
    wait_idle();

    // Readback
    issue(8'h3C, 1'b0);
    bus.ff46_rd = 1'b1;
    #1;
    chk("readback_3c", {24'd0, bus.d_out}, 32'h3C);
    bus.ff46_rd = 1'b0;
    #1;
    chk("readback_low", {24'd0, bus.d_out}, 0);
    wait_idle();
    bus.ff46_rd = 1'b1;
    issue(8'h77, 1'b1);
    #1;
    chk("readback_new", {24'd0, bus.d_out}, 32'h77);
    bus.ff46_rd = 1'b0;
    wait_idle();

    // Randomized transfers with optional restarts
    for (int i = 0; i < 6; i++) begin
      salt = 8'($urandom);
      v    = 8'($urandom_range(0, 255));
      issue(v, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 159);
        wait_byte(r);
        v = 8'($urandom_range(0, 255));
        issue(v, 1'b0);
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) next_mc();
    end
    salt = 8'h00;

    // Asynchronous reset mid-transfer
    issue(8'hC5, 1'b0);
    wait_byte(20);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_lock",   {31'd0, bus.oam_lock}, 0);
    chk("arst_oam_wr", {31'd0, bus.oam_wr}, 0);
    chk("arst_src_rd", {31'd0, bus.src_rd}, 0);
    bus.ff46_rd = 1'b1;
    #1;
    chk("arst_readback", {24'd0, bus.d_out}, 32'hFF);
    bus.ff46_rd = 1'b0;
    rq.delete();
    wq.delete();
    lo = 0;
    hi = -1;
    ff46_model = 8'hFF;
    reset = 1'b0;
    next_mc();
    issue(8'hC1, 1'b0);
    wait_idle();

    chk("final_rq_empty", rq.size(), 0);
    chk("final_wq_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
